// File: rtl/mem_stage_sram_ctrl.sv
// rtl/mem_stage_sram_ctrl.sv - MEM stage: 32-bit load/store over a 16-bit async SRAM as two half-word phases.
module mem_stage_sram_ctrl #(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Val_Rm,
  output logic [31:0] mem_result,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [16:0] waddr_q, waddr_nx;
  logic [15:0] data_hi_q, data_hi_nx;
  logic        store_q, store_nx;
  logic [15:0] low_q, low_nx;
  logic [31:0] mem_result_nx;
  logic [17:0] addr_nx;
  logic [15:0] dq_nx;
  logic        we_n_nx, oe_nx;

  logic        req;
  logic        last;
  logic [16:0] req_waddr;

  assign req       = MEM_R_EN | MEM_W_EN;
  assign last      = (cnt == LAST);
  // Byte offset in 32-bit wrap-around; dropping off[1:0] and everything above bit 18.
  assign req_waddr = 17'((ALU_result - ADDR_BASE) >> 2);

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    waddr_nx      = waddr_q;
    data_hi_nx    = data_hi_q;
    store_nx      = store_q;
    low_nx        = low_q;
    mem_result_nx = mem_result;
    addr_nx       = SRAM_ADDR;
    dq_nx         = SRAM_DQ_out;
    we_n_nx       = SRAM_WE_N;
    oe_nx         = SRAM_DQ_oe;
    ready         = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_nx   = LO;
          cnt_nx     = 4'd0;
          waddr_nx   = req_waddr;
          data_hi_nx = Val_Rm[31:16];
          store_nx   = MEM_W_EN;
          addr_nx    = {req_waddr, 1'b0};
          dq_nx      = Val_Rm[15:0];
          we_n_nx    = ~MEM_W_EN;
          oe_nx      = MEM_W_EN;
        end
      end
      LO: begin
        if (last) begin
          state_nx = HI;
          cnt_nx   = 4'd0;
          addr_nx  = {waddr_q, 1'b1};
          dq_nx    = data_hi_q;
          // One-clock WE_N high gap between the two half-word writes.
          we_n_nx  = 1'b1;
          if (!store_q) low_nx = SRAM_DQ_in;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      HI: begin
        if (last) begin
          state_nx = DONE;
          cnt_nx   = 4'd0;
          we_n_nx  = 1'b1;
          oe_nx    = 1'b0;
          if (!store_q) mem_result_nx = {SRAM_DQ_in, low_q};
        end else begin
          cnt_nx  = cnt + 4'd1;
          we_n_nx = ~store_q;
        end
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      waddr_q     <= 17'd0;
      data_hi_q   <= 16'd0;
      store_q     <= 1'b0;
      low_q       <= 16'd0;
      mem_result  <= 32'h0;
      SRAM_ADDR   <= 18'd0;
      SRAM_DQ_out <= 16'd0;
      SRAM_WE_N   <= 1'b1;
      SRAM_DQ_oe  <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      waddr_q     <= waddr_nx;
      data_hi_q   <= data_hi_nx;
      store_q     <= store_nx;
      low_q       <= low_nx;
      mem_result  <= mem_result_nx;
      SRAM_ADDR   <= addr_nx;
      SRAM_DQ_out <= dq_nx;
      SRAM_WE_N   <= we_n_nx;
      SRAM_DQ_oe  <= oe_nx;
    end
  end

endmodule
